// File: rtl/turtle_exec_core.sv
// Turtle accumulator execution core: accumulator, register file, flags,
// valid/ready instruction port and a one-bit-per-cycle shifter.
module turtle_exec_core #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    localparam int REG_ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [3:0]            instr_op,
    input  logic [REG_ADDR_W-1:0] instr_reg,
    input  logic [DATA_WIDTH-1:0] instr_imm,
    output logic [DATA_WIDTH-1:0] acc,
    output logic [3:0]            flags,
    output logic                  done,
    output logic                  err,
    input  logic [REG_ADDR_W-1:0] dbg_reg_addr,
    output logic [DATA_WIDTH-1:0] dbg_reg_data
);

    localparam int SH_W = $clog2(DATA_WIDTH);
    localparam int RF_N = 2 ** REG_ADDR_W;
    localparam int MSB  = DATA_WIDTH - 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDR  = 4'h2;
    localparam logic [3:0] OP_STR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_ASR  = 4'hC;

    localparam logic [1:0] SH_L = 2'd0;
    localparam logic [1:0] SH_R = 2'd1;
    localparam logic [1:0] SH_A = 2'd2;

    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [3:0]            flags_q, flags_d;
    logic [SH_W-1:0]       cnt_q, cnt_d;
    logic [1:0]            sop_q, sop_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rf_q [RF_N];
    logic                  rf_we;
    logic                  zn_upd;

    logic                  reg_ok;
    logic [DATA_WIDTH-1:0] opb;
    logic [DATA_WIDTH:0]   add_r;
    logic [DATA_WIDTH:0]   sub_r;
    logic [DATA_WIDTH:0]   addi_r;
    logic [SH_W-1:0]       sh_n;
    logic [DATA_WIDTH-1:0] sh_res;
    logic                  sh_c;

    assign reg_ok = int'(instr_reg) < NUM_REGS;
    assign opb    = reg_ok ? rf_q[instr_reg] : '0;
    assign sh_n   = instr_imm[SH_W-1:0];

    assign add_r  = {1'b0, acc_q} + {1'b0, opb};
    assign sub_r  = {1'b0, acc_q} + {1'b0, ~opb}
                  + (DATA_WIDTH + 1)'(1);
    assign addi_r = {1'b0, acc_q} + {1'b0, instr_imm};

    // One-bit step of the shifter; carry gets the bit that falls out.
    always_comb begin
        sh_res = acc_q;
        sh_c   = 1'b0;
        case (sop_q)
            SH_L: begin
                sh_res = {acc_q[MSB-1:0], 1'b0};
                sh_c   = acc_q[MSB];
            end
            SH_R: begin
                sh_res = {1'b0, acc_q[MSB:1]};
                sh_c   = acc_q[0];
            end
            default: begin
                sh_res = {acc_q[MSB], acc_q[MSB:1]};
                sh_c   = acc_q[0];
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rf_we   = 1'b0;
        zn_upd  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    done_d = 1'b1;
                    case (instr_op)
                        OP_NOP: ;
                        OP_LDI: begin
                            acc_d  = instr_imm;
                            zn_upd = 1'b1;
                        end
                        OP_LDR: begin
                            acc_d  = opb;
                            zn_upd = 1'b1;
                        end
                        OP_STR: rf_we = reg_ok;
                        OP_ADD: begin
                            acc_d      = add_r[MSB:0];
                            flags_d[1] = add_r[DATA_WIDTH];
                            flags_d[0] = (acc_q[MSB] == opb[MSB])
                                && (add_r[MSB] != acc_q[MSB]);
                            zn_upd     = 1'b1;
                        end
                        OP_SUB: begin
                            acc_d      = sub_r[MSB:0];
                            flags_d[1] = sub_r[DATA_WIDTH];
                            flags_d[0] = (acc_q[MSB] != opb[MSB])
                                && (sub_r[MSB] != acc_q[MSB]);
                            zn_upd     = 1'b1;
                        end
                        OP_AND: begin
                            acc_d  = acc_q & opb;
                            zn_upd = 1'b1;
                        end
                        OP_OR: begin
                            acc_d  = acc_q | opb;
                            zn_upd = 1'b1;
                        end
                        OP_XOR: begin
                            acc_d  = acc_q ^ opb;
                            zn_upd = 1'b1;
                        end
                        OP_ADDI: begin
                            acc_d      = addi_r[MSB:0];
                            flags_d[1] = addi_r[DATA_WIDTH];
                            flags_d[0] = (acc_q[MSB] == instr_imm[MSB])
                                && (addi_r[MSB] != acc_q[MSB]);
                            zn_upd     = 1'b1;
                        end
                        OP_SHL, OP_SHR, OP_ASR: begin
                            zn_upd = 1'b1;
                            sop_d  = (instr_op == OP_SHL) ? SH_L
                                   : (instr_op == OP_SHR) ? SH_R
                                   : SH_A;
                            if (sh_n != '0) begin
                                state_d = S_SHIFT;
                                cnt_d   = sh_n;
                                done_d  = 1'b0;
                            end
                        end
                        default: begin
                            done_d = 1'b0;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                acc_d      = sh_res;
                flags_d[1] = sh_c;
                zn_upd     = 1'b1;
                cnt_d      = cnt_q - SH_W'(1);
                if (cnt_q == SH_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Z/N always follow the value being written to the accumulator.
        if (zn_upd) begin
            flags_d[3] = (acc_d == '0);
            flags_d[2] = acc_d[MSB];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            sop_q   <= SH_L;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < RF_N; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (rf_we) begin
                rf_q[instr_reg] <= acc_q;
            end
        end
    end

    assign instr_ready  = ~reset & (state_q == S_IDLE);
    assign acc          = acc_q;
    assign flags        = flags_q;
    assign done         = done_q;
    assign err          = err_q;
    assign dbg_reg_data = (int'(dbg_reg_addr) < NUM_REGS)
                        ? rf_q[dbg_reg_addr] : '0;

endmodule

// File: tb/tb_turtle_exec_core.sv
// Bench for turtle_exec_core: directed scenarios plus random
// instruction streams checked against an arithmetic reference model.
module tb_turtle_exec_core;

    localparam int W   = 8;
    localparam int NR  = 4;
    localparam int RA  = 2;
    localparam int W2  = 16;
    localparam int NR2 = 3;
    localparam int RA2 = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;

    logic          valid = 1'b0;
    logic          ready;
    logic [3:0]    op = '0;
    logic [RA-1:0] rg = '0;
    logic [W-1:0]  imm = '0;
    logic [W-1:0]  acc;
    logic [3:0]    flags;
    logic          done;
    logic          err;
    logic [RA-1:0] dbga = '0;
    logic [W-1:0]  dbgd;

    logic           valid2 = 1'b0;
    logic           ready2;
    logic [3:0]     op2 = '0;
    logic [RA2-1:0] rg2 = '0;
    logic [W2-1:0]  imm2 = '0;
    logic [W2-1:0]  acc2;
    logic [3:0]     flags2;
    logic           done2;
    logic           err2;
    logic [RA2-1:0] dbga2 = '0;
    logic [W2-1:0]  dbgd2;

    int checks = 0;
    int errors = 0;

    int m_acc;
    bit mz, mn, mc, mv;
    int m_regs [NR];

    int ob, eb;
    bit odn, oer, oto, oearly, eill;

    always #5 clk = ~clk;

    turtle_exec_core #(.DATA_WIDTH(W), .NUM_REGS(NR)) u8 (
        .clk(clk), .reset(reset),
        .instr_valid(valid), .instr_ready(ready),
        .instr_op(op), .instr_reg(rg), .instr_imm(imm),
        .acc(acc), .flags(flags), .done(done), .err(err),
        .dbg_reg_addr(dbga), .dbg_reg_data(dbgd)
    );

    turtle_exec_core #(.DATA_WIDTH(W2), .NUM_REGS(NR2)) u16 (
        .clk(clk), .reset(reset),
        .instr_valid(valid2), .instr_ready(ready2),
        .instr_op(op2), .instr_reg(rg2), .instr_imm(imm2),
        .acc(acc2), .flags(flags2), .done(done2), .err(err2),
        .dbg_reg_addr(dbga2), .dbg_reg_data(dbgd2)
    );

    function automatic int sgn(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    function automatic bit ovf(input int x);
        return (x > (1 << (W - 1)) - 1) || (x < -(1 << (W - 1)));
    endfunction

    task automatic model_reset();
        m_acc = 0;
        {mz, mn, mc, mv} = 4'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 0;
    endtask

    // Reference: what the architectural state should be after one op.
    task automatic model_exec(input int o, input int r, input int im,
                              output int busy, output bit ill);
        int mask, b, s, n, res, sa;
        bit wr;
        mask = (1 << W) - 1;
        b = (r < NR) ? m_regs[r] : 0;
        busy = 0; ill = 0; wr = 0; res = m_acc;
        sa = sgn(m_acc);
        case (o)
            0: ;
            1: begin res = im; wr = 1; end
            2: begin res = b; wr = 1; end
            3: if (r < NR) m_regs[r] = m_acc;
            4, 9: begin
                if (o == 9) b = im;
                s = m_acc + b;
                mc = ((s >> W) & 1) != 0;
                mv = ovf(sa + sgn(b));
                res = s & mask; wr = 1;
            end
            5: begin
                s = m_acc + ((~b) & mask) + 1;
                mc = ((s >> W) & 1) != 0;
                mv = ovf(sa - sgn(b));
                res = s & mask; wr = 1;
            end
            6: begin res = m_acc & b; wr = 1; end
            7: begin res = m_acc | b; wr = 1; end
            8: begin res = m_acc ^ b; wr = 1; end
            10, 11, 12: begin
                n = im & ((1 << $clog2(W)) - 1);
                busy = n; wr = 1;
                if (n > 0) begin
                    if (o == 10) begin
                        mc = ((m_acc >> (W - n)) & 1) != 0;
                        res = (m_acc << n) & mask;
                    end else if (o == 11) begin
                        mc = ((m_acc >> (n - 1)) & 1) != 0;
                        res = m_acc >> n;
                    end else begin
                        mc = ((m_acc >> (n - 1)) & 1) != 0;
                        res = (sa >>> n) & mask;
                    end
                end
            end
            default: ill = 1;
        endcase
        if (wr) begin
            m_acc = res;
            mz = (res == 0);
            mn = ((res >> (W - 1)) & 1) != 0;
        end
    endtask

    // Presents one instruction at a negedge and returns at the negedge
    // where the core is ready again, reporting what it observed.
    task automatic send(input logic [3:0] o, input logic [RA-1:0] r,
                        input logic [W-1:0] im, output int busy,
                        output bit dn, output bit er, output bit to,
                        output bit early);
        valid = 1'b1; op = o; rg = r; imm = im;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        busy = 0; to = 0; early = 0;
        while (!ready && !to) begin
            if (done) early = 1;
            busy++;
            if (busy > 64) to = 1;
            else @(negedge clk);
        end
        dn = done; er = err;
    endtask

    task automatic do_op(input int o, input int r, input int im);
        model_exec(o, r, im, eb, eill);
        send(4'(o), RA'(r), W'(im), ob, odn, oer, oto, oearly);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", ready);
        end
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        checks++;
        if (acc !== 8'h00 || flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: acc %h flags %b want 00 0000",
                     acc, flags);
        end
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctl: done %b err %b ready %b want 0 0 1",
                     done, err, ready);
        end
    endtask

    task automatic test_addi_overflow();
        do_op(1, 0, 'h7F);
        checks++;
        if (odn !== 1'b1 || acc !== 8'h7F) begin
            errors++;
            $display("FAIL ldi_7f: done %b acc %h want 1 7f", odn, acc);
        end
        do_op(9, 0, 'h01);
        checks++;
        if (odn !== 1'b1 || acc !== 8'h80) begin
            errors++;
            $display("FAIL addi_acc: done %b acc %h want 1 80", odn, acc);
        end
        checks++;
        if (flags !== 4'b0101) begin
            errors++;
            $display("FAIL addi_flags: got %b want 0101", flags);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL idle_done: got %b want 0", done);
        end
    endtask

    task automatic test_sub_borrow();
        do_op(1, 0, 'h05);
        do_op(3, 2, 0);
        do_op(1, 0, 'h03);
        do_op(5, 2, 0);
        checks++;
        if (acc !== 8'hFE || flags !== 4'b0100) begin
            errors++;
            $display("FAIL sub: acc %h flags %b want fe 0100", acc, flags);
        end
        dbga = 2'd2;
        #1;
        checks++;
        if (dbgd !== 8'h05) begin
            errors++;
            $display("FAIL dbg_r2: got %h want 05", dbgd);
        end
    endtask

    task automatic test_shift();
        do_op(1, 0, 'h81);
        do_op(10, 0, 3);
        checks++;
        if (ob !== 3 || oearly !== 1'b0 || odn !== 1'b1) begin
            errors++;
            $display("FAIL shl_timing: busy %0d early %b done %b want 3 0 1",
                     ob, oearly, odn);
        end
        checks++;
        if (acc !== 8'h08 || flags[1] !== 1'b0) begin
            errors++;
            $display("FAIL shl_val: acc %h c %b want 08 0", acc, flags[1]);
        end
        do_op(1, 0, 'h88);
        do_op(12, 0, 1);
        checks++;
        if (acc !== 8'hC4 || ob !== 1) begin
            errors++;
            $display("FAIL asr: acc %h busy %0d want c4 1", acc, ob);
        end
        do_op(10, 0, 1);
        do_op(11, 0, 8);
        checks++;
        if (acc !== 8'h88 || flags !== 4'b0110 || ob !== 0 || odn !== 1) begin
            errors++;
            $display("FAIL shr_zero: acc %h fl %b busy %0d dn %b want 88 0110 0 1",
                     acc, flags, ob, odn);
        end
    endtask

    task automatic test_illegal();
        do_op(1, 0, 'h42);
        do_op(14, 0, 0);
        checks++;
        if (oer !== 1'b1 || odn !== 1'b0 || ob !== 0) begin
            errors++;
            $display("FAIL illegal_ctl: err %b done %b busy %0d want 1 0 0",
                     oer, odn, ob);
        end
        checks++;
        if (acc !== 8'h42 || flags !== {mz, mn, mc, mv}) begin
            errors++;
            $display("FAIL illegal_state: acc %h fl %b want 42 %b",
                     acc, flags, {mz, mn, mc, mv});
        end
        do_op(1, 0, 'h07);
        checks++;
        if (odn !== 1'b1 || oer !== 1'b0 || acc !== 8'h07) begin
            errors++;
            $display("FAIL after_illegal: done %b err %b acc %h want 1 0 07",
                     odn, oer, acc);
        end
    endtask

    task automatic test_reset_midshift();
        do_op(1, 0, 'h80);
        valid = 1'b1; op = 4'hB; imm = 8'd7;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL shr_busy: ready %b want 0", ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || acc !== 8'h00 || flags !== 4'h0
            || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rdy %b acc %h fl %b dn %b want 0 00 0 0",
                     ready, acc, flags, done);
        end
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        dbga = 2'd2;
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || dbgd !== 8'h00) begin
            errors++;
            $display("FAIL post_reset: rdy %b dn %b r2 %h want 1 0 00",
                     ready, done, dbgd);
        end
    endtask

    task automatic test_random();
        int o, r, im, a;
        for (int i = 0; i < 300; i++) begin
            o  = $urandom_range(0, 15);
            r  = $urandom_range(0, NR - 1);
            im = $urandom_range(0, (1 << W) - 1);
            do_op(o, r, im);
            checks++;
            if (oto || ob !== eb || oearly) begin
                errors++;
                $display("FAIL rnd_busy[%0d] op %h: busy %0d to %b early %b want %0d",
                         i, o, ob, oto, oearly, eb);
            end
            checks++;
            if (odn !== !eill || oer !== eill) begin
                errors++;
                $display("FAIL rnd_ctl[%0d] op %h: done %b err %b want %b %b",
                         i, o, odn, oer, !eill, eill);
            end
            checks++;
            if (acc !== W'(m_acc) || flags !== {mz, mn, mc, mv}) begin
                errors++;
                $display("FAIL rnd_state[%0d] op %h: acc %h fl %b want %h %b",
                         i, o, acc, flags, W'(m_acc), {mz, mn, mc, mv});
            end
            a = $urandom_range(0, NR - 1);
            dbga = RA'(a);
            #1;
            checks++;
            if (dbgd !== W'(m_regs[a])) begin
                errors++;
                $display("FAIL rnd_dbg[%0d] r%0d: got %h want %h",
                         i, a, dbgd, W'(m_regs[a]));
            end
        end
    endtask

    task automatic test_wide();
        valid2 = 1'b1; op2 = 4'h1; imm2 = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        op2 = 4'h9; imm2 = 16'h0001;
        checks++;
        if (done2 !== 1'b1 || acc2 !== 16'hFFFF || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL w_ldi: dn %b acc %h rdy %b want 1 ffff 1",
                     done2, acc2, ready2);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done2 !== 1'b1 || acc2 !== 16'h0000 || flags2 !== 4'b1010) begin
            errors++;
            $display("FAIL w_addi: dn %b acc %h fl %b want 1 0000 1010",
                     done2, acc2, flags2);
        end
        op2 = 4'h1; imm2 = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        op2 = 4'h3; rg2 = 2'd3;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done2 !== 1'b1) begin
            errors++;
            $display("FAIL w_str3_done: got %b want 1", done2);
        end
        rg2 = 2'd2;
        @(posedge clk);
        @(negedge clk);
        op2 = 4'h2; rg2 = 2'd3;
        @(posedge clk);
        @(negedge clk);
        valid2 = 1'b0;
        checks++;
        if (done2 !== 1'b1 || acc2 !== 16'h0000 || flags2[3] !== 1'b1) begin
            errors++;
            $display("FAIL w_ldr3: dn %b acc %h z %b want 1 0000 1",
                     done2, acc2, flags2[3]);
        end
        dbga2 = 2'd3;
        #1;
        checks++;
        if (dbgd2 !== 16'h0000) begin
            errors++;
            $display("FAIL w_dbg3: got %h want 0000", dbgd2);
        end
        dbga2 = 2'd2;
        #1;
        checks++;
        if (dbgd2 !== 16'h1234) begin
            errors++;
            $display("FAIL w_dbg2: got %h want 1234", dbgd2);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_addi_overflow();
        test_sub_borrow();
        test_shift();
        test_illegal();
        test_reset_midshift();
        test_random();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
